sram_stage_sequencer: RTL and testbench

SRAM_STAGE_SEQUENCER -- requirements
Module: sram_stage_sequencer

---
 rtl/sram_stage_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_sram_stage_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stage_sequencer.sv
// ---------------------------------------------------------------------------
// sram_stage_sequencer
//
// Purpose:
//   Runs a set of processing stages one after another. Each stage gets
//   exclusive use of a shared SRAM controller while it runs. After a go
//   pulse the sequencer waits START_DELAY settle cycles. It then starts
//   every enabled stage in ascending index order and waits for each stage's
//   done pulse. The bus stays idle for one cycle between stages. When every
//   enabled stage has finished, the SRAM is handed to the display reader.
//
// Optional feature:
//   `define STAGE_TIMEOUT_EN  adds a per-stage watchdog. A stage that stays
//   in RUN for TIMEOUT_CYCLES cycles without signalling done moves the
//   sequencer to ERROR and raises the error flag. Without the macro, error
//   is tied low and ERROR is never reached.
//
// Ports:
//   CLOCK_50_I       clock
//   Resetn           asynchronous active-low reset
//   go               single-cycle start/restart pulse
//   stage_mask       per-stage enable, latched on go
//   stage_start      level start to the granted stage
//   stage_done       per-stage completion pulse
//   stage_addr       packed per-stage SRAM addresses
//   stage_wdata      packed per-stage SRAM write data
//   stage_we_n       per-stage SRAM write enables (active low)
//   disp_addr        display reader address
//   disp_enable      display reader owns the SRAM
//   SRAM_address     address to the SRAM controller
//   SRAM_write_data  write data to the SRAM controller
//   SRAM_we_n        write enable to the SRAM controller (active low)
//   active_stage     index of the granted stage
//   busy             registered, high in DELAY, RUN and NEXT
//   error            stage timeout flag
// ---------------------------------------------------------------------------
module sram_stage_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int START_DELAY    = 10,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic                         CLOCK_50_I,
    input  logic                         Resetn,
    input  logic                         go,
    input  logic [NUM_STAGES-1:0]        stage_mask,
    output logic [NUM_STAGES-1:0]        stage_start,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata,
    input  logic [NUM_STAGES-1:0]        stage_we_n,
    input  logic [ADDR_W-1:0]            disp_addr,
    output logic                         disp_enable,
    output logic [ADDR_W-1:0]            SRAM_address,
    output logic [DATA_W-1:0]            SRAM_write_data,
    output logic                         SRAM_we_n,
    output logic [2:0]                   active_stage,
    output logic                         busy,
    output logic                         error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_RUN,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] DELAY_LAST = 8'(START_DELAY - 1);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [NUM_STAGES-1:0]   r_mask;
    logic [7:0]              r_delayCnt;
    logic [2:0]              r_stage;
    logic [2:0]              w_nextStage;
    logic                    r_busy;
    logic                    w_loadMask;

    logic                    w_firstValid;
    logic [2:0]              w_firstIdx;
    logic                    w_nextValid;
    logic [2:0]              w_nextIdx;
    logic                    w_activeDone;

`ifdef STAGE_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]             r_wdCnt;
    logic                    r_error;
`endif

    // Find the lowest enabled stage overall (used when leaving DELAY). Also
    // find the lowest enabled stage above the current one (used when leaving
    // NEXT). The loops walk downwards, so the lowest match is written last
    // and wins.
    always_comb begin
        w_firstValid = 1'b0;
        w_firstIdx   = 3'd0;
        w_nextValid  = 1'b0;
        w_nextIdx    = 3'd0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_firstValid = 1'b1;
                w_firstIdx   = 3'(i);
            end
            if (r_mask[i] && (3'(i) > r_stage)) begin
                w_nextValid = 1'b1;
                w_nextIdx   = 3'(i);
            end
        end
    end

    // Only the granted stage's done bit matters. All other done bits are
    // ignored.
    always_comb begin
        w_activeDone = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_stage == 3'(i)) begin
                w_activeDone = stage_done[i];
            end
        end
    end

    // Next-state logic. A go pulse is honoured only in IDLE, DONE and ERROR.
    // In RUN, stage_done therefore always wins over a simultaneous go.
    always_comb begin
        w_nextState = r_state;
        w_nextStage = r_stage;
        w_loadMask  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_nextState = S_DELAY;
                    w_loadMask  = 1'b1;
                end
            end
            S_DELAY: begin
                if (r_delayCnt == DELAY_LAST) begin
                    if (w_firstValid) begin
                        w_nextState = S_RUN;
                        w_nextStage = w_firstIdx;
                    end else begin
                        w_nextState = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (w_activeDone) begin
                    w_nextState = S_NEXT;
                end
`ifdef STAGE_TIMEOUT_EN
                else if (r_wdCnt == WD_LAST) begin
                    w_nextState = S_ERROR;
                end
`endif
            end
            S_NEXT: begin
                if (w_nextValid) begin
                    w_nextState = S_RUN;
                    w_nextStage = w_nextIdx;
                end else begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                if (go) begin
                    w_nextState = S_DELAY;
                    w_loadMask  = 1'b1;
                end
            end
            S_ERROR: begin
`ifdef STAGE_TIMEOUT_EN
                if (go) begin
                    w_nextState = S_DELAY;
                    w_loadMask  = 1'b1;
                end
`else
                w_nextState = S_IDLE;
`endif
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // State, mask, delay counter and busy registers. busy is computed from
    // the next state, so it changes on the same edge as the state.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_stage    <= 3'd0;
            r_mask     <= '0;
            r_delayCnt <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_stage <= w_nextStage;
            r_busy  <= (w_nextState == S_DELAY) || (w_nextState == S_RUN) ||
                       (w_nextState == S_NEXT);
            if (w_loadMask) begin
                r_mask     <= stage_mask;
                r_delayCnt <= 8'd0;
            end else if (r_state == S_DELAY) begin
                r_delayCnt <= r_delayCnt + 8'd1;
            end
        end
    end

`ifdef STAGE_TIMEOUT_EN
    // Watchdog: restarts from zero on every RUN entry and counts each RUN
    // cycle. error is registered and follows entry into ERROR.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_wdCnt <= 32'd0;
            r_error <= 1'b0;
        end else begin
            if ((w_nextState == S_RUN) && (r_state != S_RUN)) begin
                r_wdCnt <= 32'd0;
            end else if (r_state == S_RUN) begin
                r_wdCnt <= r_wdCnt + 32'd1;
            end
            r_error <= (w_nextState == S_ERROR);
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // Stage starts and SRAM bus mux. The granted stage drives the bus
    // combinationally with no added latency. The display reader owns the
    // bus in DONE. Every other state leaves the bus idle.
    always_comb begin
        stage_start     = '0;
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        if (r_state == S_RUN) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (r_stage == 3'(i)) begin
                    stage_start[i]  = 1'b1;
                    SRAM_address    = stage_addr[i*ADDR_W +: ADDR_W];
                    SRAM_write_data = stage_wdata[i*DATA_W +: DATA_W];
                    SRAM_we_n       = stage_we_n[i];
                end
            end
        end else if (r_state == S_DONE) begin
            SRAM_address = disp_addr;
        end
    end

    assign disp_enable  = (r_state == S_DONE);
    assign active_stage = r_stage;
    assign busy         = r_busy;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sram_stage_sequencer
//
// Purpose:
//   Directed-plus-random bench for sram_stage_sequencer. For each mask the
//   reference model builds the expected order of stages: every set mask bit,
//   in ascending index order. For every cycle the bench then predicts the
//   expected start vector, grant index, bus contents, busy and display
//   enable. Unrelated done bits and go pulses are injected at random and
//   must have no effect. Define STAGE_TIMEOUT_EN to also exercise the
//   watchdog with a 16-cycle limit.
// ---------------------------------------------------------------------------
module tb_sram_stage_sequencer;

    localparam int NS = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int SD = 10;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              go;
    logic [NS-1:0]     stageMask;
    logic [NS-1:0]     stageStart;
    logic [NS-1:0]     stageDone;
    logic [NS*AW-1:0]  stageAddr;
    logic [NS*DW-1:0]  stageWdata;
    logic [NS-1:0]     stageWeN;
    logic [AW-1:0]     dispAddr;
    logic              dispEnable;
    logic [AW-1:0]     sramAddress;
    logic [DW-1:0]     sramWriteData;
    logic              sramWeN;
    logic [2:0]        activeStage;
    logic              busy;
    logic              error;

    int compared   = 0;
    int mismatched = 0;

    logic [AW-1:0] addrArr [NS];
    logic [DW-1:0] dataArr [NS];
    logic          weArr   [NS];

    sram_stage_sequencer #(
        .NUM_STAGES    (NS),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .START_DELAY   (SD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLOCK_50_I     (clk),
        .Resetn         (rstn),
        .go             (go),
        .stage_mask     (stageMask),
        .stage_start    (stageStart),
        .stage_done     (stageDone),
        .stage_addr     (stageAddr),
        .stage_wdata    (stageWdata),
        .stage_we_n     (stageWeN),
        .disp_addr      (dispAddr),
        .disp_enable    (dispEnable),
        .SRAM_address   (sramAddress),
        .SRAM_write_data(sramWriteData),
        .SRAM_we_n      (sramWeN),
        .active_stage   (activeStage),
        .busy           (busy),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < NS; k++) begin
            addrArr[k] = AW'($urandom);
            dataArr[k] = DW'($urandom);
            weArr[k]   = 1'($urandom);
            stageAddr[k*AW +: AW]  = addrArr[k];
            stageWdata[k*DW +: DW] = dataArr[k];
            stageWeN[k]            = weArr[k];
        end
        dispAddr = AW'($urandom);
    endtask

    task automatic checkIdle(input string tag, input logic expBusy);
        checkOutput({tag, "_start"}, stageStart, '0);
        checkOutput({tag, "_addr"}, sramAddress, '0);
        checkOutput({tag, "_wdata"}, sramWriteData, '0);
        checkOutput({tag, "_we_n"}, sramWeN, 1'b1);
        checkOutput({tag, "_busy"}, busy, expBusy);
        checkOutput({tag, "_disp"}, dispEnable, 1'b0);
    endtask

    task automatic checkRun(input int k);
        applyStimulus();
        #1;
        checkOutput("run_start", stageStart, 64'(1) << k);
        checkOutput("run_active", activeStage, k);
        checkOutput("run_addr", sramAddress, addrArr[k]);
        checkOutput("run_wdata", sramWriteData, dataArr[k]);
        checkOutput("run_we_n", sramWeN, weArr[k]);
        checkOutput("run_busy", busy, 1'b1);
        checkOutput("run_disp", dispEnable, 1'b0);
        checkOutput("run_error", error, 1'b0);
    endtask

    task automatic checkDone();
        applyStimulus();
        #1;
        checkOutput("done_disp", dispEnable, 1'b1);
        checkOutput("done_addr", sramAddress, dispAddr);
        checkOutput("done_we_n", sramWeN, 1'b1);
        checkOutput("done_wdata", sramWriteData, '0);
        checkOutput("done_busy", busy, 1'b0);
        checkOutput("done_start", stageStart, '0);
    endtask

    // go in IDLE/DONE/ERROR, then START_DELAY settle cycles with an idle bus
    task automatic startSeq(input logic [NS-1:0] m);
        stageMask = m;
        go = 1'b1;
        tick();
        go = 1'b0;
        stageMask = NS'($urandom);
        for (int c = 0; c < SD; c++) begin
            #1;
            checkIdle("delay", 1'b1);
            tick();
        end
    endtask

    // Random hold in RUN(k) with foreign done bits and go, then done[k]
    task automatic runStage(input int k);
        logic [NS-1:0] onlyK;
        int            holds;
        onlyK = NS'(1) << k;
        holds = $urandom_range(0, 3);
        for (int h = 0; h < holds; h++) begin
            stageDone = NS'($urandom) & ~onlyK;
            go = 1'($urandom);
            checkRun(k);
            tick();
        end
        stageDone = onlyK | (NS'($urandom) & ~onlyK);
        go = 1'($urandom);
        checkRun(k);
        tick();
        stageDone = '0;
        go = 1'b0;
        #1;
        checkIdle("next", 1'b1);
        tick();
    endtask

    task automatic fullSeq(input logic [NS-1:0] m);
        int order [$];
        for (int i = 0; i < NS; i++) begin
            if (m[i]) order.push_back(i);
        end
        startSeq(m);
        foreach (order[j]) runStage(order[j]);
        checkDone();
        tick();
        checkDone();
    endtask

    initial begin
        rstn = 1'b1;
        go = 1'b0;
        stageMask = '0;
        stageDone = '0;
        stageAddr = '0;
        stageWdata = '0;
        stageWeN = '0;
        dispAddr = '0;
        #1;
        rstn = 1'b0;
        #3;
        applyStimulus();
        #1;
        checkIdle("reset", 1'b0);
        checkOutput("reset_active", activeStage, 3'd0);
        checkOutput("reset_error", error, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        #1;
        checkIdle("idle", 1'b0);

        fullSeq(3'b111);
        fullSeq(3'b101);
        fullSeq(3'b000);
        fullSeq(3'b010);
        for (int r = 0; r < 8; r++) fullSeq(NS'($urandom));

        // Reset asserted in the middle of RUN(1)
        startSeq(3'b111);
        runStage(0);
        stageDone = 3'b101;
        checkRun(1);
        rstn = 1'b0;
        #1;
        checkIdle("midreset", 1'b0);
        checkOutput("midreset_active", activeStage, 3'd0);
        checkOutput("midreset_error", error, 1'b0);
        tick();
        stageDone = '0;
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            checkIdle("postreset", 1'b0);
        end
        fullSeq(3'b110);

`ifdef STAGE_TIMEOUT_EN
        // Stage 0 never finishes: ERROR after TO RUN cycles, go recovers
        startSeq(3'b001);
        for (int c = 0; c < TO; c++) begin
            stageDone = '0;
            checkRun(0);
            tick();
        end
        #1;
        checkIdle("timeout", 1'b0);
        checkOutput("timeout_error", error, 1'b1);
        checkOutput("timeout_active", activeStage, 3'd0);
        tick();
        checkOutput("timeout_hold", error, 1'b1);
        stageMask = 3'b011;
        go = 1'b1;
        tick();
        go = 1'b0;
        #1;
        checkOutput("recover_error", error, 1'b0);
        checkOutput("recover_busy", busy, 1'b1);
        for (int c = 1; c < SD; c++) tick();
        runStage(0);
        runStage(1);
        checkDone();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
